// File: rtl/xlr8_xb_pin_arb_pkg.sv
// Shared types and constants for the XB pin arbiter: per-pin state encoding,
// owner-index width helper and release hold-off counter width.
package xlr8_xb_pin_arb_pkg;

   typedef enum logic [1:0] {
      FREE      = 2'd0,
      OWNED     = 2'd1,
      RELEASING = 2'd2
   } pin_state_t;

   localparam int REL_CNT_W = 4;

   function automatic int own_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/xlr8_xb_pin_owner.sv
// One pin's ownership FSM: claim by lowest requester, hold-off on release,
// registered override outputs from the next owner, sticky conflict flag.
module xlr8_xb_pin_owner
   import xlr8_xb_pin_arb_pkg::*;
#(
   parameter int NUM_XBS        = 4,
   parameter int RELEASE_CYCLES = 2,
   parameter int OWN_W          = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_XBS-1:0] ddoe_i,
   input  logic [NUM_XBS-1:0] ddov_i,
   input  logic [NUM_XBS-1:0] pvoe_i,
   input  logic [NUM_XBS-1:0] pvov_i,
   input  logic               conflict_clr,
   output logic               ddoe_o,
   output logic               ddov_o,
   output logic               pvoe_o,
   output logic               pvov_o,
   output logic               owned_o,
   output logic [OWN_W-1:0]   owner_o,
   output logic               conflict_o,
   output logic               conflict_det_o
);

   localparam logic [REL_CNT_W-1:0] CNT_INIT =
      REL_CNT_W'((RELEASE_CYCLES == 0) ? 0 : RELEASE_CYCLES - 1);

   logic [NUM_XBS-1:0]   req, own_mask;
   logic [OWN_W-1:0]     low_idx;
   logic                 owner_req, other_req, conflict_det;
   pin_state_t           state_q, state_d;
   logic [OWN_W-1:0]     owner_q, owner_d;
   logic [REL_CNT_W-1:0] cnt_q, cnt_d;
   logic                 ddoe_q, ddoe_d, ddov_q, ddov_d;
   logic                 pvoe_q, pvoe_d, pvov_q, pvov_d;
   logic                 conflict_q, conflict_d;

   always_comb begin
      req     = ddoe_i | pvoe_i;
      low_idx = '0;
      for (int i = NUM_XBS - 1; i >= 0; i--) begin
         if (req[i]) low_idx = OWN_W'(i);
      end
      own_mask = '0;
      for (int i = 0; i < NUM_XBS; i++) own_mask[i] = (int'(owner_q) == i);
      owner_req = |(req & own_mask);
      other_req = |(req & ~own_mask);

      state_d      = state_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      conflict_det = 1'b0;
      case (state_q)
         FREE: begin
            conflict_det = ($countones(req) > 1);
            if (|req) begin
               state_d = OWNED;
               owner_d = low_idx;
            end
         end
         OWNED: begin
            conflict_det = other_req;
            if (!owner_req) begin
               if (RELEASE_CYCLES == 0) begin
                  state_d = FREE;
                  owner_d = '0;
               end else begin
                  state_d = RELEASING;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         RELEASING: begin
            // Only the previous owner may reclaim during the hold-off.
            conflict_det = other_req;
            if (owner_req) begin
               state_d = OWNED;
            end else if (cnt_q == '0) begin
               state_d = FREE;
               owner_d = '0;
            end else begin
               cnt_d = cnt_q - REL_CNT_W'(1);
            end
         end
         default: begin
            state_d = FREE;
            owner_d = '0;
         end
      endcase

      ddoe_d = 1'b0;
      ddov_d = 1'b0;
      pvoe_d = 1'b0;
      pvov_d = 1'b0;
      if (state_d == OWNED) begin
         for (int i = 0; i < NUM_XBS; i++) begin
            if (int'(owner_d) == i) begin
               ddoe_d = ddoe_i[i];
               ddov_d = ddoe_i[i] & ddov_i[i];
               pvoe_d = pvoe_i[i];
               pvov_d = pvoe_i[i] & pvov_i[i];
            end
         end
      end
      conflict_d = conflict_det | (conflict_q & ~conflict_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FREE;
         owner_q    <= '0;
         cnt_q      <= '0;
         ddoe_q     <= 1'b0;
         ddov_q     <= 1'b0;
         pvoe_q     <= 1'b0;
         pvov_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         ddoe_q     <= ddoe_d;
         ddov_q     <= ddov_d;
         pvoe_q     <= pvoe_d;
         pvov_q     <= pvov_d;
         conflict_q <= conflict_d;
      end
   end

   assign ddoe_o         = ddoe_q;
   assign ddov_o         = ddov_q;
   assign pvoe_o         = pvoe_q;
   assign pvov_o         = pvov_q;
   assign owned_o        = (state_q == OWNED);
   assign owner_o        = owner_q;
   assign conflict_o     = conflict_q;
   assign conflict_det_o = conflict_det;

endmodule

// File: rtl/xlr8_xb_pin_arbiter.sv
// XB pin mux with per-pin ownership arbitration. Optional saturating conflict
// counter enabled by defining XB_PIN_ARB_CONFLICT_CNT_EN.
module xlr8_xb_pin_arbiter
   import xlr8_xb_pin_arb_pkg::*;
#(
   parameter int NUM_PINS       = 20,
   parameter int NUM_XBS        = 4,
   parameter int RELEASE_CYCLES = 2
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_XBS-1:0][NUM_PINS-1:0]            xbs_ddoe,
   input  logic [NUM_XBS-1:0][NUM_PINS-1:0]            xbs_ddov,
   input  logic [NUM_XBS-1:0][NUM_PINS-1:0]            xbs_pvoe,
   input  logic [NUM_XBS-1:0][NUM_PINS-1:0]            xbs_pvov,
   input  logic                                        conflict_clr,
   output logic [NUM_PINS-1:0]                         xb_ddoe,
   output logic [NUM_PINS-1:0]                         xb_ddov,
   output logic [NUM_PINS-1:0]                         xb_pvoe,
   output logic [NUM_PINS-1:0]                         xb_pvov,
   output logic [NUM_PINS-1:0]                         xb_owned,
   output logic [NUM_PINS-1:0][own_w(NUM_XBS)-1:0]     xb_owner,
   output logic [NUM_PINS-1:0]                         xb_conflict,
   output logic [7:0]                                  conflict_cnt
);

   localparam int OWN_W = own_w(NUM_XBS);

   logic [NUM_PINS-1:0][NUM_XBS-1:0] ddoe_t, ddov_t, pvoe_t, pvov_t;
   logic [NUM_PINS-1:0]              conflict_det;

   always_comb begin
      for (int p = 0; p < NUM_PINS; p++) begin
         for (int i = 0; i < NUM_XBS; i++) begin
            ddoe_t[p][i] = xbs_ddoe[i][p];
            ddov_t[p][i] = xbs_ddov[i][p];
            pvoe_t[p][i] = xbs_pvoe[i][p];
            pvov_t[p][i] = xbs_pvov[i][p];
         end
      end
   end

   for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
      xlr8_xb_pin_owner #(
         .NUM_XBS        (NUM_XBS),
         .RELEASE_CYCLES (RELEASE_CYCLES),
         .OWN_W          (OWN_W)
      ) u_owner (
         .clk            (clk),
         .rst            (rst),
         .ddoe_i         (ddoe_t[p]),
         .ddov_i         (ddov_t[p]),
         .pvoe_i         (pvoe_t[p]),
         .pvov_i         (pvov_t[p]),
         .conflict_clr   (conflict_clr),
         .ddoe_o         (xb_ddoe[p]),
         .ddov_o         (xb_ddov[p]),
         .pvoe_o         (xb_pvoe[p]),
         .pvov_o         (xb_pvov[p]),
         .owned_o        (xb_owned[p]),
         .owner_o        (xb_owner[p]),
         .conflict_o     (xb_conflict[p]),
         .conflict_det_o (conflict_det[p])
      );
   end

`ifdef XB_PIN_ARB_CONFLICT_CNT_EN
   logic       any_conflict;
   logic [7:0] conflict_cnt_q, conflict_cnt_d;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A conflict in the same cycle as a clear still counts.
   always_comb begin
      any_conflict   = |conflict_det;
      conflict_cnt_d = conflict_cnt_q;
      if (any_conflict) conflict_cnt_d = sat_inc(conflict_cnt_q);
      else if (conflict_clr) conflict_cnt_d = 8'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) conflict_cnt_q <= 8'h0;
      else     conflict_cnt_q <= conflict_cnt_d;
   end

   assign conflict_cnt = conflict_cnt_q;
`else
   logic unused_conflict_det;
   assign unused_conflict_det = |conflict_det;
   assign conflict_cnt        = 8'h0;
`endif

endmodule

// File: tb/tb_xlr8_xb_pin_arbiter.sv
// Directed + randomized bench for xlr8_xb_pin_arbiter against a pin-ownership
// reference model (owner index / remaining hold-off per pin).
module tb_xlr8_xb_pin_arbiter;
   import xlr8_xb_pin_arb_pkg::*;

   localparam int NP    = 20;
   localparam int NX    = 4;
   localparam int RC    = 2;
   localparam int OWN_W = own_w(NX);

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic [NX-1:0][NP-1:0]        xbs_ddoe = '0, xbs_ddov = '0, xbs_pvoe = '0, xbs_pvov = '0;
   logic                         conflict_clr = 1'b0;
   logic [NP-1:0]                xb_ddoe, xb_ddov, xb_pvoe, xb_pvov, xb_owned, xb_conflict;
   logic [NP-1:0][OWN_W-1:0]     xb_owner;
   logic [7:0]                   conflict_cnt;

   int checks = 0;
   int failures = 0;

   // Reference model: owner index (-1 = free), hold-off edges left (-1 = actively held).
   int                       m_owner [NP];
   int                       m_left  [NP];
   logic [NP-1:0]            m_conf;
   int                       m_cnt;
   logic [NP-1:0]            e_ddoe, e_ddov, e_pvoe, e_pvov, e_owned;
   logic [NP-1:0][OWN_W-1:0] e_owner;

   xlr8_xb_pin_arbiter #(.NUM_PINS(NP), .NUM_XBS(NX), .RELEASE_CYCLES(RC)) dut (
      .clk(clk), .rst(rst),
      .xbs_ddoe(xbs_ddoe), .xbs_ddov(xbs_ddov), .xbs_pvoe(xbs_pvoe), .xbs_pvov(xbs_pvov),
      .conflict_clr(conflict_clr),
      .xb_ddoe(xb_ddoe), .xb_ddov(xb_ddov), .xb_pvoe(xb_pvoe), .xb_pvov(xb_pvov),
      .xb_owned(xb_owned), .xb_owner(xb_owner), .xb_conflict(xb_conflict),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_owner[p] = -1;
         m_left[p]  = -1;
      end
      m_conf = '0; m_cnt = 0;
      e_ddoe = '0; e_ddov = '0; e_pvoe = '0; e_pvov = '0; e_owned = '0; e_owner = '0;
   endtask

   task automatic model_step();
      bit any_det = 0;
      for (int p = 0; p < NP; p++) begin
         int  nreq = 0, low = -1, o;
         bit  det, oreq, act;
         for (int i = 0; i < NX; i++) begin
            if (xbs_ddoe[i][p] | xbs_pvoe[i][p]) begin
               nreq++;
               if (low < 0) low = i;
            end
         end
         if (m_owner[p] < 0) begin
            det = (nreq > 1);
            if (nreq > 0) begin m_owner[p] = low; m_left[p] = -1; end
         end else begin
            o    = m_owner[p];
            oreq = xbs_ddoe[o][p] | xbs_pvoe[o][p];
            det  = (nreq - int'(oreq)) > 0;
            if (m_left[p] < 0) begin
               if (!oreq) begin
                  if (RC == 0) m_owner[p] = -1;
                  else         m_left[p]  = RC - 1;
               end
            end else if (oreq)         m_left[p] = -1;
            else if (m_left[p] == 0) begin m_owner[p] = -1; m_left[p] = -1; end
            else                       m_left[p]--;
         end
         m_conf[p] = det | (m_conf[p] & ~conflict_clr);
         any_det |= det;
         act = (m_owner[p] >= 0) && (m_left[p] < 0);
         o   = (m_owner[p] >= 0) ? m_owner[p] : 0;
         e_owned[p] = act;
         e_owner[p] = OWN_W'(o);
         e_ddoe[p]  = act & xbs_ddoe[o][p];
         e_ddov[p]  = act & xbs_ddoe[o][p] & xbs_ddov[o][p];
         e_pvoe[p]  = act & xbs_pvoe[o][p];
         e_pvov[p]  = act & xbs_pvoe[o][p] & xbs_pvov[o][p];
      end
`ifdef XB_PIN_ARB_CONFLICT_CNT_EN
      if (any_det)           m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else if (conflict_clr) m_cnt = 0;
`else
      m_cnt = 0;
`endif
   endtask

   task automatic chk_all();
      chk("ddoe", xb_ddoe, e_ddoe);
      chk("ddov", xb_ddov, e_ddov);
      chk("pvoe", xb_pvoe, e_pvoe);
      chk("pvov", xb_pvov, e_pvov);
      chk("owned", xb_owned, e_owned);
      chk("owner", xb_owner, e_owner);
      chk("conflict", xb_conflict, m_conf);
      chk("conflict_cnt", conflict_cnt, 64'(m_cnt));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all();
      chk("reset_owned", xb_owned, 0);
      rst = 1'b0;

      // First claim right after reset
      xbs_pvoe[1][5] = 1'b1; xbs_pvov[1][5] = 1'b1;
      tick();
      chk("claim_pvoe5", xb_pvoe[5], 1);
      chk("claim_pvov5", xb_pvov[5], 1);
      chk("claim_owner5", xb_owner[5], 1);
      chk("claim_owned5", xb_owned[5], 1);

      // Simultaneous claim of pin 3 by XB0 and XB2
      xbs_ddoe[0][3] = 1'b1; xbs_ddov[0][3] = 1'b0;
      xbs_ddoe[2][3] = 1'b1; xbs_ddov[2][3] = 1'b1;
      xbs_pvoe[2][3] = 1'b1; xbs_pvov[2][3] = 1'b1;
      repeat (3) begin
         tick();
         chk("pin3_owner", xb_owner[3], 0);
         chk("pin3_conflict", xb_conflict[3], 1);
         chk("pin3_ddov", xb_ddov[3], 0);
         chk("pin3_pvoe", xb_pvoe[3], 0);
      end

      // XB1 releases pin 5 while XB3 keeps requesting it
      xbs_pvoe[1][5] = 1'b0; xbs_pvov[1][5] = 1'b0;
      xbs_pvoe[3][5] = 1'b1; xbs_pvov[3][5] = 1'b1;
      tick();
      chk("rel_pvoe5_a", xb_pvoe[5], 0);
      chk("rel_owner5_a", xb_owner[5], 1);
      chk("rel_conflict5", xb_conflict[5], 1);
      tick();
      chk("rel_pvoe5_b", xb_pvoe[5], 0);
      tick();
      chk("rel_free5", xb_owner[5], 0);
      chk("rel_pvoe5_c", xb_pvoe[5], 0);
      tick();
      chk("reclaim_owner5", xb_owner[5], 3);
      chk("reclaim_pvov5", xb_pvov[5], 1);

      // Owner drops and reasserts inside the hold-off; XB0 stays blocked
      xbs_pvoe[3][5] = 1'b0;
      xbs_ddoe[0][5] = 1'b1; xbs_ddov[0][5] = 1'b1;
      tick();
      chk("hold_owned5", xb_owned[5], 0);
      xbs_pvoe[3][5] = 1'b1;
      repeat (2) begin
         tick();
         chk("hold_back_owner5", xb_owner[5], 3);
         chk("hold_back_owned5", xb_owned[5], 1);
         chk("hold_back_ddoe5", xb_ddoe[5], 0);
      end

      // Long conflict run for counter saturation
      repeat (300) tick();
`ifdef XB_PIN_ARB_CONFLICT_CNT_EN
      chk("cnt_saturate", conflict_cnt, 255);
`else
      chk("cnt_tied_zero", conflict_cnt, 0);
`endif
      xbs_ddoe = '0; xbs_ddov = '0; xbs_pvoe = '0; xbs_pvov = '0;
      tick();
      conflict_clr = 1'b1;
      tick();
      conflict_clr = 1'b0;
      chk("clr_cnt", conflict_cnt, 0);
      chk("clr_conflict", xb_conflict, 0);
      repeat (4) tick();

      // Async reset with pin 7 owned and pin 9 releasing
      xbs_ddoe[2][7] = 1'b1; xbs_ddov[2][7] = 1'b1;
      xbs_pvoe[1][9] = 1'b1;
      tick();
      xbs_pvoe[1][9] = 1'b0;
      tick();
      chk("pre_rst_owned7", xb_owned[7], 1);
      rst = 1'b1;
      #2;
      model_reset();
      chk_all();
      chk("rst_async_ddoe", xb_ddoe, 0);
      #1;
      rst = 1'b0;
      xbs_ddoe = '0; xbs_ddov = '0; xbs_pvoe = '0; xbs_pvov = '0;
      xbs_pvoe[3][7] = 1'b1; xbs_pvov[3][7] = 1'b1;
      tick();
      chk("post_rst_owner7", xb_owner[7], 3);
      chk("post_rst_pvov7", xb_pvov[7], 1);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NX; i++) begin
            for (int p = 0; p < NP; p++) begin
               if ($urandom_range(0, 7) == 0) xbs_ddoe[i][p] = ~xbs_ddoe[i][p];
               if ($urandom_range(0, 7) == 0) xbs_pvoe[i][p] = ~xbs_pvoe[i][p];
               if ($urandom_range(0, 3) == 0) xbs_ddov[i][p] = ~xbs_ddov[i][p];
               if ($urandom_range(0, 3) == 0) xbs_pvov[i][p] = ~xbs_pvov[i][p];
            end
         end
         if (c % 150 == 149) begin
            xbs_ddoe = '0; xbs_pvoe = '0;
         end
         conflict_clr = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
